// File: rtl/burst_cache_if.sv
// burst_cache_if: CPU load/store + BurstRAM bundle; slave = cache side, master = CPU/RAM side
interface burst_cache_if #(parameter int DW = 8, parameter int BW = 64);
  logic en, valid, err, bsy, flush;
  logic [1:0] we;
  logic [2:0] re;
  logic [31:0] addr, din, dout;
  logic br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
  logic [DW-1:0] br_addr;
  logic [BW-1:0] br_wr_data, br_rd_data;
  logic [BW/8-1:0] br_data_mask;
  modport slave (
    input en, we, re, addr, din, flush, br_rd_data, br_rd_data_valid, br_busy,
    output dout, valid, err, bsy, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );
  modport master (
    output en, we, re, addr, din, flush, br_rd_data, br_rd_data_valid, br_busy,
    input dout, valid, err, bsy, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );
endinterface

// File: rtl/burst_cache.sv
// burst_cache: direct-mapped write-back cache; ports clk, rst (async, high), bus_io (burst_cache_if.slave: CPU load/store side + BurstRAM side)
module burst_cache #(
  parameter int RAM_DEPTH_BITWIDTH = 8,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT = 4,
  parameter int CACHE_LINE_IX_BITWIDTH = 2
) (
  input logic clk,
  input logic rst,
  burst_cache_if.slave bus_io
);
  localparam int DW = RAM_DEPTH_BITWIDTH;
  localparam int BW = RAM_BURST_DATA_BITWIDTH;
  localparam int CNT = RAM_BURST_DATA_COUNT;
  localparam int IXW = CACHE_LINE_IX_BITWIDTH;
  localparam int LINES = 1 << IXW;
  localparam int LW = CNT * BW;
  localparam int OFF = $clog2(LW / 8);
  localparam int TW = 32 - OFF - IXW;
  localparam int CB = $clog2(CNT);
  localparam int BC = CB > 0 ? CB : 1;
  typedef enum logic [2:0] {IDLE, WB, RD_CMD, RD_DATA, DONE, FLUSH_SCAN} state_t;
  state_t state_q, state_d;
  logic [BC-1:0] beat_q, beat_d;
  logic [IXW-1:0] scan_q, scan_d, ix, vix;
  logic fl_q, fl_d, valid_q, err_q;
  logic [31:0] req_addr_q, req_din_q, dout_q, a, d, word, sh, lde;
  logic [1:0] req_we_q, we, sz;
  logic [2:0] req_re_q, re;
  logic [LINES-1:0] vld_q, dirty_q;
  logic [TW-1:0] tag_q [LINES];
  logic [LW-1:0] data_q [LINES];
  logic [TW-1:0] tag;
  logic [OFF+2:0] wpos;
  logic [3:0] be;
  logic [31:0] wd;
  logic idle, st, ld, mis, hit, last;
  logic acc, do_op, do_err, fl_done, fill, wb_clr, cmd, cmd_en;
  logic [DW-1:0] baddr, rd_baddr, wb_baddr;
  logic [BW-1:0] wdat;
  // Outside IDLE the latched request drives lookup, so DONE replays it as a hit.
  assign idle = state_q == IDLE;
  assign a = idle ? bus_io.addr : req_addr_q;
  assign d = idle ? bus_io.din : req_din_q;
  assign we = idle ? bus_io.we : req_we_q;
  assign re = idle ? bus_io.re : req_re_q;
  assign st = we != 2'd0;
  assign ld = !st && re[1:0] != 2'd0;
  assign sz = st ? we : re[1:0];
  assign mis = (sz == 2'd2 && a[0]) || (sz == 2'd3 && a[1:0] != 2'd0);
  assign tag = a[31 -: TW];
  assign ix = a[OFF +: IXW];
  assign vix = fl_q ? scan_q : ix;
  assign hit = vld_q[ix] && tag_q[ix] == tag;
  assign wpos = {a[OFF-1:0] & ~OFF'(3), 3'b000};
  assign word = data_q[ix][wpos +: 32];
  assign sh = word >> {a[1:0], 3'b000};
  assign lde = sz == 2'd1 ? {{24{re[2] & sh[7]}}, sh[7:0]} :
               sz == 2'd2 ? {{16{re[2] & sh[15]}}, sh[15:0]} : sh;
  assign be = (sz == 2'd1 ? 4'b0001 : sz == 2'd2 ? 4'b0011 : 4'b1111) << a[1:0];
  assign wd = d << {a[1:0], 3'b000};
  assign last = beat_q == BC'(CNT - 1);
  assign rd_baddr = DW'(32'({tag, ix}) << CB);
  assign wb_baddr = DW'(32'({tag_q[vix], vix}) << CB);
  assign bus_io.dout = dout_q;
  assign bus_io.valid = valid_q;
  assign bus_io.err = err_q;
  assign bus_io.bsy = !idle;
  assign bus_io.br_cmd = cmd;
  assign bus_io.br_cmd_en = cmd_en;
  assign bus_io.br_addr = baddr;
  assign bus_io.br_wr_data = wdat;
  assign bus_io.br_data_mask = '0;
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    scan_d = scan_q;
    fl_d = fl_q;
    acc = 1'b0;
    do_op = 1'b0;
    do_err = 1'b0;
    fl_done = 1'b0;
    fill = 1'b0;
    wb_clr = 1'b0;
    cmd = 1'b0;
    cmd_en = 1'b0;
    baddr = '0;
    wdat = '0;
    case (state_q)
      IDLE: if (bus_io.en) begin
        do_err = mis;
        do_op = !mis && (!(st || ld) || hit);
        acc = !mis && (st || ld) && !hit;
        state_d = !acc ? IDLE : (vld_q[ix] && dirty_q[ix]) ? WB : RD_CMD;
      end else if (bus_io.flush) begin
        state_d = FLUSH_SCAN;
        scan_d = '0;
        fl_d = 1'b1;
      end
      WB: begin
        cmd = 1'b1;
        baddr = wb_baddr;
        // only the command beat waits for br_busy; later beats stream unconditionally
        if (beat_q != '0 || !bus_io.br_busy) begin
          cmd_en = beat_q == '0;
          wdat = data_q[vix][beat_q * BW +: BW];
          beat_d = last ? '0 : beat_q + 1'b1;
          wb_clr = last;
          state_d = !last ? WB : fl_q ? FLUSH_SCAN : RD_CMD;
        end
      end
      RD_CMD: begin
        baddr = rd_baddr;
        cmd_en = !bus_io.br_busy;
        state_d = bus_io.br_busy ? RD_CMD : RD_DATA;
      end
      RD_DATA: if (bus_io.br_rd_data_valid) begin
        fill = 1'b1;
        beat_d = last ? '0 : beat_q + 1'b1;
        state_d = last ? DONE : RD_DATA;
      end
      DONE: begin
        do_op = 1'b1;
        state_d = IDLE;
      end
      FLUSH_SCAN: if (vld_q[scan_q] && dirty_q[scan_q]) state_d = WB;
        else if (scan_q == IXW'(LINES - 1)) begin
          fl_done = 1'b1;
          fl_d = 1'b0;
          state_d = IDLE;
        end else scan_d = scan_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q <= '0;
      scan_q <= '0;
      fl_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      dout_q <= '0;
      req_addr_q <= '0;
      req_din_q <= '0;
      req_we_q <= '0;
      req_re_q <= '0;
      vld_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      scan_q <= scan_d;
      fl_q <= fl_d;
      valid_q <= do_op || do_err || fl_done;
      err_q <= do_err;
      dout_q <= (do_op && ld) ? lde : '0;
      if (acc) begin
        req_addr_q <= bus_io.addr;
        req_din_q <= bus_io.din;
        req_we_q <= bus_io.we;
        req_re_q <= bus_io.re;
      end
      if (fill && last) begin
        vld_q[ix] <= 1'b1;
        dirty_q[ix] <= 1'b0;
      end
      if (do_op && st) dirty_q[ix] <= 1'b1;
      if (wb_clr) dirty_q[vix] <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (fill) data_q[ix][beat_q * BW +: BW] <= bus_io.br_rd_data;
    if (fill && last) tag_q[ix] <= tag;
    if (do_op && st)
      for (int k = 0; k < 4; k++)
        if (be[k]) data_q[ix][wpos + 8 * k +: 8] <= wd[8 * k +: 8];
  end
endmodule
